// File: rtl/d_bus_mux_n.sv
//------------------------------------------------------------------------------
// Module  : d_bus_mux_n
// Brief   : Data-side bus mux from core load/store port to NUM_SLV address regions
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module d_bus_mux_n #(
    parameter int                            XLEN     = 32,
    parameter int                            ADDR_LEN = 16,
    parameter int                            NUM_SLV  = 2,
    parameter logic [NUM_SLV*ADDR_LEN-1:0]   SLV_BASE = {16'h8000, 16'h0000},
    parameter logic [NUM_SLV*ADDR_LEN-1:0]   SLV_MASK = {16'hC000, 16'hF000},
    parameter int unsigned                   TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [ADDR_LEN-1:0]        addr,
    input  logic                       rd_req,
    input  logic                       wr_req,
    input  logic [XLEN/8-1:0]          be,
    input  logic [XLEN-1:0]            wr_data,
    output logic                       rd_ready,
    output logic                       wr_ready,
    output logic [XLEN-1:0]            rd_data,
    output logic                       err,
    output logic [ADDR_LEN-1:0]        s_addr,
    output logic [XLEN/8-1:0]          s_be,
    output logic [XLEN-1:0]            s_wr_data,
    output logic [NUM_SLV-1:0]         s_rd_en,
    output logic [NUM_SLV-1:0]         s_wr_en,
    input  logic [NUM_SLV*XLEN-1:0]    s_rd_data,
    input  logic [NUM_SLV-1:0]         s_rd_ready,
    input  logic [NUM_SLV-1:0]         s_wr_ready
);

    localparam int              BE_W  = XLEN / 8;
    localparam int              IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [8:0]      c_TMO = 9'(TIMEOUT);
    localparam logic [ADDR_LEN-1:0] c_ALIGN = {{(ADDR_LEN-2){1'b1}}, 2'b00};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next;

    logic                r_dir;      // 1 = write
    logic [IDX_W-1:0]    r_idx;
    logic [BE_W-1:0]     r_be;
    logic [XLEN-1:0]     r_wdata;
    logic [ADDR_LEN-1:0] r_saddr;
    logic [XLEN-1:0]     r_rdata;
    logic                r_err;
    logic [7:0]          r_cnt;

    logic                w_req;
    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [ADDR_LEN-1:0] w_hit_mask;
    logic                w_sel_rdy;
    logic [XLEN-1:0]     w_sel_rdata;
    logic                w_tmo;

    assign w_req = rd_req | wr_req;
    assign w_tmo = ({1'b0, r_cnt} + 9'd1) >= c_TMO;

    // Walk downwards so the lowest-index hit is the one left standing.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_mask = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_LEN +: ADDR_LEN]) ==
                (SLV_BASE[i*ADDR_LEN +: ADDR_LEN] & SLV_MASK[i*ADDR_LEN +: ADDR_LEN])) begin
                w_hit      = 1'b1;
                w_hit_idx  = IDX_W'(i);
                w_hit_mask = SLV_MASK[i*ADDR_LEN +: ADDR_LEN];
            end
        end
    end

    always_comb begin
        w_sel_rdy   = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_rdy   = r_dir ? s_wr_ready[i] : s_rd_ready[i];
                w_sel_rdata = s_rd_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = w_hit ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (w_sel_rdy || w_tmo) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_ready = 1'b0;
        wr_ready = 1'b0;
        err      = 1'b0;
        s_rd_en  = '0;
        s_wr_en  = '0;
        if (r_state == S_DONE) begin
            rd_ready = ~r_dir;
            wr_ready = r_dir;
            err      = r_err;
        end
        if (r_state == S_BUSY) begin
            for (int i = 0; i < NUM_SLV; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    s_rd_en[i] = ~r_dir;
                    s_wr_en[i] = r_dir;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_dir   <= 1'b0;
            r_idx   <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_saddr <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_req) begin
                        r_dir   <= wr_req;
                        r_idx   <= w_hit_idx;
                        r_be    <= be;
                        r_wdata <= wr_data;
                        r_saddr <= (addr & ~w_hit_mask) & c_ALIGN;
                        r_err   <= ~w_hit;
                        if (!w_hit && !wr_req) begin
                            r_rdata <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_sel_rdy) begin
                        r_err <= 1'b0;
                        if (!r_dir) begin
                            r_rdata <= w_sel_rdata;
                        end
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                        if (!r_dir) begin
                            r_rdata <= '0;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign rd_data   = r_rdata;
    assign s_addr    = r_saddr;
    assign s_be      = r_be;
    assign s_wr_data = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_d_bus_mux_n.sv
//------------------------------------------------------------------------------
// Module  : tb_d_bus_mux_n
// Brief   : Self-checking bench for d_bus_mux_n, directed plus randomized accesses
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_d_bus_mux_n;

    localparam int          XLEN = 32;
    localparam int          AL   = 16;
    localparam int          NS   = 2;
    localparam int unsigned TO   = 4;

    logic              clk = 1'b0;
    logic              rstb;
    logic [AL-1:0]     addr;
    logic              rd_req, wr_req;
    logic [3:0]        be;
    logic [XLEN-1:0]   wr_data;
    logic              rd_ready, wr_ready, err;
    logic [XLEN-1:0]   rd_data;
    logic [AL-1:0]     s_addr;
    logic [3:0]        s_be;
    logic [XLEN-1:0]   s_wr_data;
    logic [NS-1:0]     s_rd_en, s_wr_en;
    logic [NS*XLEN-1:0] s_rd_data;
    logic [NS-1:0]     s_rd_ready, s_wr_ready;

    d_bus_mux_n #(
        .XLEN     (XLEN),
        .ADDR_LEN (AL),
        .NUM_SLV  (NS),
        .SLV_BASE ({16'h8000, 16'h0000}),
        .SLV_MASK ({16'hC000, 16'hF000}),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .addr       (addr),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .be         (be),
        .wr_data    (wr_data),
        .rd_ready   (rd_ready),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .err        (err),
        .s_addr     (s_addr),
        .s_be       (s_be),
        .s_wr_data  (s_wr_data),
        .s_rd_en    (s_rd_en),
        .s_wr_en    (s_wr_en),
        .s_rd_data  (s_rd_data),
        .s_rd_ready (s_rd_ready),
        .s_wr_ready (s_wr_ready)
    );

    always #5 clk = ~clk;

    // Region map of the reference model
    logic [AL-1:0] m_base [NS];
    logic [AL-1:0] m_mask [NS];

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] prev_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 64'({rd_ready, wr_ready, err, rd_data, s_rd_en, s_wr_en}), 64'd0);
        chk({tag, "_addr"}, 64'({s_addr, s_be}), 64'd0);
        chk({tag, "_wdata"}, 64'(s_wr_data), 64'd0);
    endtask

    // One master access with a slave answering in BUSY cycle d (d > TO never answers in time).
    task automatic access(input bit is_wr, input logic [15:0] a, input logic [3:0] b,
                          input logic [31:0] wd, input int d, input logic [31:0] sd);
        int          region;
        int          exp_lat;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [1:0]  vec;
        logic [15:0] exp_sa;
        int          cyc;
        bit          got;

        region = -1;
        for (int i = 0; i < NS; i++)
            if (region < 0 && (a & m_mask[i]) == (m_base[i] & m_mask[i])) region = i;
        vec    = '0;
        exp_sa = '0;
        if (region < 0) begin
            exp_lat = 1;
            exp_err = 1'b1;
        end else begin
            vec    = 2'(1 << region);
            exp_sa = (a & ~m_mask[region]) & 16'hFFFC;
            if (d <= int'(TO)) begin
                exp_lat = d + 1;
                exp_err = 1'b0;
            end else begin
                exp_lat = int'(TO) + 1;
                exp_err = 1'b1;
            end
        end
        exp_rd = is_wr ? prev_rd : (exp_err ? 32'd0 : sd);

        chk("idle_rd_data_hold", 64'(rd_data), 64'(prev_rd));

        addr      = a;
        be        = b;
        wr_data   = wd;
        rd_req    = ~is_wr;
        wr_req    = is_wr;
        s_rd_data = {$urandom, $urandom};
        if (region >= 0) s_rd_data[region*32 +: 32] = sd;
        s_rd_ready = '0;
        s_wr_ready = '0;

        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (rd_ready || wr_ready) begin
                got = 1'b1;
                chk("done_enables_off", 64'({s_rd_en, s_wr_en}), 64'd0);
            end else begin
                if (cyc < exp_lat) begin
                    chk("busy_rd_en", 64'(s_rd_en), 64'(is_wr ? 2'b00 : vec));
                    chk("busy_wr_en", 64'(s_wr_en), 64'(is_wr ? vec : 2'b00));
                end
                if (cyc == 1 && region >= 0) begin
                    chk("s_addr", 64'(s_addr), 64'(exp_sa));
                    chk("s_be", 64'(s_be), 64'(b));
                    chk("s_wr_data", 64'(s_wr_data), 64'(wd));
                end
                // Post-acceptance input churn and stray readies must be ignored
                addr       = 16'($urandom);
                be         = 4'($urandom);
                wr_data    = $urandom;
                s_rd_ready = 2'($urandom) & ~vec;
                s_wr_ready = 2'($urandom) & ~vec;
                if (is_wr) s_rd_ready = s_rd_ready | (vec & 2'($urandom));
                else       s_wr_ready = s_wr_ready | (vec & 2'($urandom));
                if (region >= 0 && cyc == d) begin
                    if (is_wr) s_wr_ready = s_wr_ready | vec;
                    else       s_rd_ready = s_rd_ready | vec;
                end
            end
        end

        chk("ready_seen", 64'(got), 64'd1);
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("ready_dir", 64'({rd_ready, wr_ready}), 64'(is_wr ? 2'b01 : 2'b10));
        chk("err", 64'(err), 64'(exp_err));
        chk("rd_data", 64'(rd_data), 64'(exp_rd));

        rd_req     = 1'b0;
        wr_req     = 1'b0;
        s_rd_ready = '0;
        s_wr_ready = '0;
        @(posedge clk); #1;
        chk("single_pulse", 64'({rd_ready, wr_ready, err}), 64'd0);
        prev_rd = exp_rd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int          sel;

        m_base[0] = 16'h0000; m_mask[0] = 16'hF000;
        m_base[1] = 16'h8000; m_mask[1] = 16'hC000;

        rstb       = 1'b0;
        addr       = '0;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        be         = '0;
        wr_data    = '0;
        s_rd_data  = '0;
        s_rd_ready = '0;
        s_wr_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rstb = 1'b1;
        @(posedge clk); #1;

        access(1'b0, 16'h8010, 4'hF, 32'h0, 1, 32'hDEADBEEF);
        access(1'b1, 16'h0006, 4'b0011, 32'h0000_1234, 3, 32'h0);
        access(1'b0, 16'h4000, 4'hF, 32'h0, 1, 32'h5555_5555);
        access(1'b0, 16'h0ABC, 4'hF, 32'h0, 2, 32'hCAFE_F00D);
        access(1'b0, 16'h0100, 4'hF, 32'h0, 7, 32'hAAAA_AAAA);
        access(1'b0, 16'h8FFC, 4'hF, 32'h0, 4, 32'h1357_9BDF);
        access(1'b1, 16'h7000, 4'hF, 32'h0BAD_0BAD, 1, 32'h0);

        // Simultaneous read and write to the same region: write first, then read
        addr       = 16'h8000;
        be         = 4'hF;
        wr_data    = 32'h1111_2222;
        rd_req     = 1'b1;
        wr_req     = 1'b1;
        s_rd_data  = {32'h3333_4444, 32'h0};
        s_rd_ready = 2'b10;
        s_wr_ready = 2'b10;
        @(posedge clk); #1;
        chk("both_wr_en", 64'(s_wr_en), 64'(2'b10));
        chk("both_rd_en_off", 64'(s_rd_en), 64'd0);
        @(posedge clk); #1;
        chk("both_wr_ready", 64'({rd_ready, wr_ready}), 64'(2'b01));
        wr_req = 1'b0;
        @(posedge clk); #1;
        chk("both_gap", 64'({rd_ready, wr_ready, s_rd_en, s_wr_en}), 64'd0);
        @(posedge clk); #1;
        chk("both_rd_en", 64'({s_rd_en, s_wr_en}), 64'(4'b1000));
        @(posedge clk); #1;
        chk("both_rd_ready", 64'({rd_ready, wr_ready, err}), 64'(3'b100));
        chk("both_rd_data", 64'(rd_data), 64'(32'h3333_4444));
        rd_req     = 1'b0;
        s_rd_ready = '0;
        s_wr_ready = '0;
        @(posedge clk); #1;
        chk("both_idle", 64'({rd_ready, wr_ready}), 64'd0);
        prev_rd = 32'h3333_4444;

        // Asynchronous reset in the second BUSY cycle
        addr   = 16'h8010;
        be     = 4'hF;
        rd_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_busy", 64'(s_rd_en), 64'(2'b10));
        rstb = 1'b0;
        #1;
        chk_zero("async_reset");
        rd_req = 1'b0;
        @(posedge clk); #1;
        rstb    = 1'b1;
        prev_rd = '0;
        @(posedge clk); #1;
        access(1'b0, 16'h8020, 4'hF, 32'h0, 2, 32'h0BAD_CAFE);

        for (int k = 0; k < 80; k++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      a = {4'h0, 12'($urandom)};
            else if (sel == 1) a = {2'b10, 14'($urandom)};
            else               a = 16'($urandom);
            access(1'($urandom), a, 4'($urandom), $urandom, int'($urandom_range(1, 6)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
